// File: rtl/seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_pkg
// Brief    : Shared constants, state encoding and helpers for the BCD
//            scan display (segment patterns, digit counts, dabble step).
// Revision : 1.0 - initial release
// ============================================================================
package seg_display_pkg;

  localparam int BCD_DIGITS  = 5;
  localparam int DISP_DIGITS = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  // Active-high segments, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift the
  // next binary bit in. The top adjusted bit cannot be set for 16-bit input,
  // so it is dropped by the truncating cast.
  function automatic logic [19:0] dabble_step(input logic [19:0] bcd,
                                              input logic        msb);
    logic [19:0] a;
    a = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return 20'({a, msb});
  endfunction

  // Leading-zero mask: digit 3 downward until the first nonzero digit.
  // Digit 0 is always shown.
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'd0);
    m[2] = m[3] && (v[11:8] == 4'd0);
    m[1] = m[2] && (v[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Brief    : Combinational 4-bit nibble to 7-segment (active-high) decoder.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_decode
  import seg_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Standard hex glyph table; anything unexpected shows blank
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg_bcd_scan_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_bcd_scan_display
// Brief    : Captures a 16-bit value via valid/ready, converts it to BCD with
//            a one-bit-per-clock double dabble and scans it onto a 4-digit
//            multiplexed 7-segment display.
//            Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Revision : 1.0 - initial release
// ============================================================================
module seg_bcd_scan_display
  import seg_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit HEX_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        upd_pulse,
  output logic        ovf,
  output logic [3:0]  dig_en,
  output logic [6:0]  seg
);

  localparam logic [19:0] PRE_LAST = 20'(SCAN_DIV - 1);

  state_t      state_q,  state_d;
  logic [15:0] bin_q,    bin_d;
  logic [19:0] bcd_q,    bcd_d;
  logic [4:0]  count_q,  count_d;
  logic [15:0] disp_q,   disp_d;
  logic        ovf_q,    ovf_d;
  logic        upd_q,    upd_d;
  logic [19:0] pre_q,    pre_d;
  logic [1:0]  idx_q,    idx_d;
  logic [3:0]  dig_en_q, dig_en_d;
  logic [6:0]  seg_q,    seg_d;

  logic [19:0] bcd_next;
  logic [3:0]  nib_mux;
  logic [6:0]  seg_dec;
  logic [3:0]  disp_blank;

  assign bcd_next = dabble_step(bcd_q, bin_q[15]);

  // Capture / conversion FSM; the display register only moves on commit
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    count_d = count_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    upd_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (HEX_MODE) begin
            disp_d = in_data;
            ovf_d  = 1'b0;
            upd_d  = 1'b1;
          end else begin
            bin_d   = in_data;
            bcd_d   = '0;
            count_d = 5'd16;
            state_d = ST_CONV;
          end
        end
      end
      ST_CONV: begin
        bcd_d   = bcd_next;
        bin_d   = {bin_q[14:0], 1'b0};
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          disp_d  = bcd_next[15:0];
          ovf_d   = (bcd_next[19:16] != 4'd0);
          upd_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign disp_blank = lead_zero_mask(disp_d);
`else
  assign disp_blank = 4'b0000;
`endif

  // Free-running digit scan; outputs are built from next-state values so
  // seg and dig_en register on the same edge as the index/display change
  always_comb begin
    pre_d = pre_q + 20'd1;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
    nib_mux  = disp_d[{idx_d, 2'b00} +: 4];
    dig_en_d = disp_blank[idx_d] ? 4'b0000   : (4'b0001 << idx_d);
    seg_d    = disp_blank[idx_d] ? SEG_BLANK : seg_dec;
  end

  seg7_decode u_seg7_decode (
    .nib (nib_mux),
    .seg (seg_dec)
  );

  // State registers with asynchronous reset to the "0000" display
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      count_q  <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      upd_q    <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      dig_en_q <= 4'b0001;
      seg_q    <= SEG_0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      upd_q    <= upd_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      dig_en_q <= dig_en_d;
      seg_q    <= seg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CONV);
  assign upd_pulse = upd_q;
  assign ovf       = ovf_q;
  assign dig_en    = dig_en_q;
  assign seg       = seg_q;

endmodule
`default_nettype wire
